// File: rtl/nios2_debug_ocimem_master.sv
// nios2_debug_ocimem_master: JTAG-debug strobes to single-word Avalon-MM accesses with auto-increment.
// Define NIOS2_OCIMEM_TIMEOUT_EN to abort accesses stalled for TIMEOUT_CYC cycles.
module nios2_debug_ocimem_master #(
  parameter int ADDR_W      = 11,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, mon_q, mon_d;
  logic              err_q, err_d, rd_q, wr_q;
  logic              strobe, done, abort;
  logic              jdo_unused;
  assign jdo_unused = ^{jdo[37], jdo[35], jdo[1:0]};
  assign strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign done   = (state_q != IDLE) && !avm_waitrequest;
`ifdef NIOS2_OCIMEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CW-1:0] cnt_q;
  // Held at zero in IDLE so every access starts counting from zero.
  always_ff @(posedge clk) begin
    if (reset || state_q == IDLE) cnt_q <= '0;
    else if (avm_waitrequest) cnt_q <= cnt_q + 1'b1;
  end
  assign abort = (state_q != IDLE) && avm_waitrequest && (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYC;
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mon_d   = mon_q;
    err_d   = err_q;
    if (state_q == IDLE) begin
      if (take_action_ocimem_a) begin
        addr_d  = {jdo[ADDR_W-1:2], 2'b00};
        err_d   = 1'b0;
        state_d = jdo[36] ? RD : IDLE;
      end else if (take_action_ocimem_b) begin
        wdata_d = jdo[34:3];
        state_d = WR;
      end else if (take_no_action_ocimem_a) begin
        state_d = RD;
      end
    end else begin
      // Strobes during an access are dropped; they only flag the error.
      err_d = err_q | strobe;
      if (done) begin
        state_d = IDLE;
        addr_d  = addr_q + ADDR_W'(4);
        mon_d   = (state_q == RD) ? avm_readdata : mon_q;
      end else if (abort) begin
        state_d = IDLE;
        err_d   = 1'b1;
        mon_d   = 32'hDEADBEEF;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mon_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mon_q   <= mon_d;
      err_q   <= err_d;
      rd_q    <= state_d == RD;
      wr_q    <= state_d == WR;
    end
  end
  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;
  assign MonDReg        = mon_q;
  assign monitor_error  = err_q;
  assign monitor_ready  = state_q == IDLE;
  assign busy           = state_q != IDLE;
endmodule
